// File: rtl/regfile_pkg.sv
// Shared register-file types: address/data widths, write-back source ids and request record.
package regfile_pkg;

    localparam int REG_AW = 3;
    localparam int REG_DW = 8;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_MOV = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wb_req_t;

    // Up to four requesters, so a 4-bit one-hot covers every legal configuration.
    function automatic logic [1:0] onehot4_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = idx | 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational one-hot arbiter: round-robin from ptr with REGFILE_WB_ARB_RR_EN, else fixed lowest-index priority.
// Zero latency; en=0 forces every grant low.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt
);

`ifdef REGFILE_WB_ARB_RR_EN
    // Two passes: indices at or above ptr first, then the wrapped-around ones below it.
    always_comb begin
        logic found;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i < int'(ptr))) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
        if (!en) gnt = '0;
    end
`else
    logic ptr_unused;
    assign ptr_unused = ^ptr;

    always_comb begin
        logic found;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
        if (!en) gnt = '0;
    end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: one grant per cycle into a registered write stage (REGFILE_WB_ARB_RR_EN selects round-robin).
// Handshake in N drives write_enable in N+1; flush or reset hold every req_ready low.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = REG_AW,
    parameter int DW   = REG_DW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 flush,
    output logic                 write_enable,
    output logic [AW-1:0]        reg_write,
    output logic [DW-1:0]        data_in,
    output logic [1:0]           grant_id,
    output logic [(1<<AW)-1:0]   busy_mask
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] gnt;
    logic            arb_en;
    logic            hs;
    logic [1:0]      gnt_idx;
    logic [3:0]      gnt_pad;
    logic [AW-1:0]   addr_sel;
    logic [DW-1:0]   data_sel;
    logic [PW-1:0]   ptr_w;

    logic            we_q,   we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic [1:0]      gid_q,  gid_d;

    assign arb_en = !flush && !reset;

    rr_arbiter #(
        .N  (NREQ),
        .PW (PW)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr_w),
        .en  (arb_en),
        .gnt (gnt)
    );

    assign req_ready = gnt;
    assign hs        = |gnt;

    always_comb begin
        gnt_pad             = '0;
        gnt_pad[NREQ-1:0]   = gnt;
        gnt_idx             = onehot4_to_idx(gnt_pad);
    end

    always_comb begin
        addr_sel = '0;
        data_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                addr_sel = req_addr[i*AW +: AW];
                data_sel = req_data[i*DW +: DW];
            end
        end
    end

    // Address, data and id hold across idle cycles; only the strobe drops.
    always_comb begin
        we_d   = hs;
        addr_d = addr_q;
        data_d = data_q;
        gid_d  = gid_q;
        if (hs) begin
            addr_d = addr_sel;
            data_d = data_sel;
            gid_d  = gnt_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            gid_q  <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            gid_q  <= gid_d;
        end
    end

`ifdef REGFILE_WB_ARB_RR_EN
    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        int nxt;
        nxt   = int'(gnt_idx) + 1;
        if (nxt >= NREQ) nxt = 0;
        ptr_d = ptr_q;
        if (hs) ptr_d = PW'(nxt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

    assign ptr_w = ptr_q;
`else
    assign ptr_w = '0;
`endif

    assign write_enable = we_q;
    assign reg_write    = addr_q;
    assign data_in      = data_q;
    assign grant_id     = gid_q;

    always_comb begin
        busy_mask = '0;
        if (we_q) busy_mask[addr_q] = 1'b1;
    end

endmodule
